// File: rtl/bcd_decoder_if.sv
// Handshake and data bundle between BCD entry logic and the BCD-to-binary converter.
// The master side issues requests; the slave side (the converter) reports status and result.
interface bcd_decoder_if;
    logic        start;
    logic        sign;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [3:0]  digit4;
    logic [3:0]  digit5;
    logic [3:0]  digit6;
    logic        busy;
    logic        done;
    logic        error;
    logic [20:0] signedOutput;

    modport master (
        output start, sign, digit1, digit2, digit3, digit4, digit5, digit6,
        input  busy, done, error, signedOutput
    );

    modport slave (
        input  start, sign, digit1, digit2, digit3, digit4, digit5, digit6,
        output busy, done, error, signedOutput
    );
endinterface

// File: rtl/bcd_decoder.sv
// Sequential BCD-to-binary converter. Six BCD digits plus a sign are captured on
// start, folded MSD-first into an unsigned accumulator (acc*10 + digit, one digit
// per clock) and finally turned into a 21-bit two's-complement result.
// Requests containing a non-BCD nibble finish one cycle after acceptance with
// error set and the previous result left untouched.
module bcd_decoder (
    input  logic              clk,
    input  logic              reset_n,
    bcd_decoder_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_sign;
    logic [23:0]         r_digits;    // MSD in [23:20]; shifted left once per step
    logic [19:0]         r_acc;
    logic [2:0]          r_step;
    logic                r_err_pend;  // accepted request held a non-BCD nibble
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic signed [20:0]  r_out;

    logic [23:0]         w_req_digits;
    logic [3:0]          w_cur_digit;

    // True when any nibble of the packed digit word exceeds 9.
    function automatic logic f_any_invalid(input logic [23:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (digits[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One accumulation step: acc*10 + digit, with the multiply as two shifts.
    // The largest intermediate (99999*10+9) fits in 20 bits, so no overflow.
    function automatic logic [19:0] f_mac10(input logic [19:0] acc, input logic [3:0] digit);
        return (acc << 3) + (acc << 1) + {16'd0, digit};
    endfunction

    // Magnitude plus sign to two's complement; a zero magnitude stays zero.
    function automatic logic signed [20:0] f_apply_sign(input logic neg, input logic [19:0] mag);
        logic signed [20:0] pos;
        pos = signed'({1'b0, mag});
        return neg ? (~pos + 21'sd1) : pos;
    endfunction

    assign w_req_digits = {bus.digit6, bus.digit5, bus.digit4,
                           bus.digit3, bus.digit2, bus.digit1};
    assign w_cur_digit  = r_digits[23:20];

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.signedOutput = r_out;

    // Control FSM with registered status outputs and the accumulation datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sign     <= 1'b0;
            r_digits   <= 24'd0;
            r_acc      <= 20'd0;
            r_step     <= 3'd0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_out      <= 21'sd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign   <= bus.sign;
                        r_digits <= w_req_digits;
                        r_error  <= 1'b0;
                        r_acc    <= 20'd0;
                        r_step   <= 3'd0;
                        if (f_any_invalid(w_req_digits)) begin
                            // Skip accumulation; FINISH reports the error next cycle.
                            r_err_pend <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_FINISH;
                        end else begin
                            r_err_pend <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_CONVERT;
                        end
                    end
                end

                S_CONVERT: begin
                    r_acc    <= f_mac10(r_acc, w_cur_digit);
                    r_digits <= r_digits << 4;
                    r_step   <= r_step + 3'd1;
                    if (r_step == 3'd5) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_err_pend <= 1'b0;
                    if (r_err_pend) begin
                        r_error <= 1'b1;
                    end else begin
                        r_out <= f_apply_sign(r_sign, r_acc);
                    end
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
